sqrl_input_filter: RTL

Parametrised multi-channel input conditioner for asynchronous serial and control pins entering the `clk` domain. Each channel gets a synchroniser of configurable depth and an odd-window majority-vote noise filter. Each channel also provides registered rise/fall strobes and a saturating count of rejected glitches. It sits between the pad and any UART receiver or control-pin consumer, generalising the fixed 2-stage / 3-sample single-line filter.

---
 rtl/sqrl_filter_pkg.sv | 38 +++
 rtl/sqrl_filter_channel.sv | 129 ++++++++++++
 rtl/sqrl_input_filter.sv | 46 ++++
 3 files changed

// File: rtl/sqrl_filter_pkg.sv
// sqrl_filter_pkg: shared constants and helpers for the sqrl input filter.
//   MAX_WINDOW / MIN_SYNC / MAX_SYNC / MAX_CNT_W : legal parameter ranges
//   clog2()        : ceiling log2 for constant sizing
//   popcount15()   : number of set bits in a 15-bit vector
//   window_legal() : true when a vote window is odd and in range
package sqrl_filter_pkg;

  localparam int unsigned MAX_WINDOW = 15;
  localparam int unsigned MIN_SYNC   = 2;
  localparam int unsigned MAX_SYNC   = 4;
  localparam int unsigned MAX_CNT_W  = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width able to hold a count of 0..MAX_WINDOW.
  localparam int unsigned ONES_W = clog2(MAX_WINDOW + 1);

  function automatic logic [ONES_W-1:0] popcount15(input logic [MAX_WINDOW-1:0] v);
    logic [ONES_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(MAX_WINDOW); i++) begin
      c = c + ONES_W'(v[i]);
    end
    return c;
  endfunction

  function automatic bit window_legal(input int unsigned w);
    return (w >= 1) && (w <= MAX_WINDOW) && (w % 2 == 1);
  endfunction

endpackage

// File: rtl/sqrl_filter_channel.sv
// sqrl_filter_channel: one input channel -- synchroniser, majority-vote window,
// registered level and edge strobes, and a saturating rejected-glitch counter.
//   clk, reset  : clock and synchronous active-high reset
//   din         : raw asynchronous input
//   cnt_clear   : synchronous clear of the glitch counter (beats an increment)
//   dout        : filtered registered level
//   rise, fall  : one-cycle strobes coincident with a dout change
//   glitch_cnt  : saturating count of pulses that never reached dout
module sqrl_filter_channel
  import sqrl_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WINDOW      = 3,
  parameter int unsigned CNT_W       = 8,
  parameter logic        IDLE        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             cnt_clear,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] glitch_cnt
);

  if (!window_legal(WINDOW)) begin : g_bad_window
    $error("sqrl_filter_channel: WINDOW must be odd and within 1..15");
  end
  if (SYNC_STAGES < MIN_SYNC || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
    $error("sqrl_filter_channel: SYNC_STAGES must be within 2..4");
  end
  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt
    $error("sqrl_filter_channel: CNT_W must be within 1..16");
  end

  localparam logic [ONES_W-1:0] Thresh = ONES_W'((WINDOW + 1) / 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic [MAX_WINDOW-1:0]  win;
  logic                   vote;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   run_q, run_d;
  logic                   cnt_inc;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  if (WINDOW > 1) begin : g_hist
    // Oldest sample sits in the MSB.
    logic [WINDOW-2:0] hist_q, hist_d;

    always_comb begin
      hist_d = {hist_q[WINDOW-3:0], s};
    end

    always_ff @(posedge clk) begin
      if (reset) hist_q <= {(WINDOW - 1){IDLE}};
      else       hist_q <= hist_d;
    end

    always_comb begin
      win                = '0;
      win[WINDOW-1:0]    = {hist_q, s};
    end
  end else begin : g_no_hist
    always_comb begin
      win    = '0;
      win[0] = s;
    end
  end

  assign vote = (popcount15(win) >= Thresh);

  always_comb begin
    dout_d  = vote;
    rise_d  = vote & ~dout_q;
    fall_d  = ~vote & dout_q;
    run_d   = run_q;
    cnt_inc = 1'b0;
    // run marks a disagreement that has not (yet) won the vote.
    if (vote != dout_q) begin
      run_d = 1'b0;
    end else if (run_q && (s == dout_q)) begin
      run_d   = 1'b0;
      cnt_inc = 1'b1;
    end else if (s != dout_q) begin
      run_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      dout_q <= IDLE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = cnt_q;

endmodule

// File: rtl/sqrl_input_filter.sv
// sqrl_input_filter: WIDTH independent input conditioners (synchroniser plus
// odd-window majority filter) with edge strobes and per-channel glitch counts.
//   clk, reset  : clock and synchronous active-high reset
//   din         : raw asynchronous inputs
//   cnt_clear   : synchronous clear of every glitch counter
//   dout        : filtered registered levels (IDLE after reset)
//   rise, fall  : per-channel one-cycle edge strobes
//   glitch_cnt  : channel i in bits [i*CNT_W +: CNT_W]
module sqrl_input_filter
  import sqrl_filter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      WINDOW      = 3,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [WIDTH-1:0] IDLE        = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  input  logic                   cnt_clear,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic [WIDTH*CNT_W-1:0] glitch_cnt
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    sqrl_filter_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .WINDOW     (WINDOW),
      .CNT_W      (CNT_W),
      .IDLE       (IDLE[i])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .din       (din[i]),
      .cnt_clear (cnt_clear),
      .dout      (dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .glitch_cnt(glitch_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule
